btn_conditioner: RTL and testbench

Five-channel push-button conditioner between the board buttons and the VGA input-control stage. Each raw, bouncy, asynchronous button is synchronised, debounced and turned into a single-cycle press pulse, with optional auto-repeat while held. The pulses drive the zoom, offset and sample-clock selection controllers directly as SW1..SW5. Bit 0 is SW1 and bit 4 is SW5.

---
 rtl/btn_conditioner.sv | 110 +++++++++++
 tb/tb_btn_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchronise, debounce, press pulse and auto-repeat for push buttons
module btn_conditioner #(
    parameter int               N_BTN           = 5,
    parameter bit               ACTIVE_LOW      = 1'b1,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00011,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic [N_BTN-1:0] w_raw;
    logic [N_BTN-1:0] r_meta;
    logic [N_BTN-1:0] r_sync;
    logic [N_BTN-1:0] r_pulse;
    logic [N_BTN-1:0] r_level;
    state_t           r_state [N_BTN];
    logic [DW-1:0]    r_dcnt  [N_BTN];
    logic [RW-1:0]    r_rcnt  [N_BTN];

    assign w_raw     = ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign btn_pulse = r_pulse;
    assign btn_level = r_level;

    // two-flop synchroniser, resets to the not-pressed level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // independent debounce/repeat state machine per channel with registered pulse and level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= IDLE;
                r_dcnt[i]  <= '0;
                r_rcnt[i]  <= '0;
            end
            r_pulse <= '0;
            r_level <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_pulse[i] <= 1'b0;
                case (r_state[i])
                    IDLE: begin
                        if (r_sync[i]) begin
                            r_state[i] <= PRESS_WAIT;
                            r_dcnt[i]  <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!r_sync[i]) begin
                            r_state[i] <= IDLE;
                            r_dcnt[i]  <= '0;
                        end else if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                            r_state[i] <= HELD;
                            r_pulse[i] <= 1'b1;
                            r_level[i] <= 1'b1;
                            r_dcnt[i]  <= '0;
                            r_rcnt[i]  <= RW'(REPEAT_DELAY);
                        end else begin
                            r_dcnt[i] <= r_dcnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!r_sync[i]) begin
                            r_state[i] <= RELEASE_WAIT;
                            r_dcnt[i]  <= '0;
                        end else if (REPEAT_MASK[i]) begin
                            if (r_rcnt[i] == RW'(1)) begin
                                r_pulse[i] <= 1'b1;
                                r_rcnt[i]  <= RW'(REPEAT_PERIOD);
                            end else begin
                                r_rcnt[i] <= r_rcnt[i] - 1'b1;
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (r_sync[i]) begin
                            r_state[i] <= HELD;
                            r_rcnt[i]  <= RW'(REPEAT_DELAY);
                        end else if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                            r_state[i] <= IDLE;
                            r_level[i] <= 1'b0;
                            r_dcnt[i]  <= '0;
                        end else begin
                            r_dcnt[i] <= r_dcnt[i] + 1'b1;
                        end
                    end
                    default: r_state[i] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce, press pulse, auto-repeat and reset behaviour
module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int pc [5];
    int pt [5][16];
    logic [4:0] lvl_seen;
    int rep [7] = '{6, 26, 34, 42, 50, 58, 66};
    int t;
    int r;

    btn_conditioner #(
        .N_BTN(5), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4),
        .REPEAT_MASK(5'b00011), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_pulse(btn_pulse), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // free-running edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // record pulse edges and sticky level per channel
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (btn_pulse[i] === 1'b1) begin
                if (pc[i] < 16) pt[i][pc[i]] = cyc;
                pc[i] = pc[i] + 1;
            end
            if (btn_level[i] === 1'b1) lvl_seen[i] = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 5; i++) pc[i] = 0;
        lvl_seen = '0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = '0;
        clr();
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(btn_pulse), 0);
        chk("rst_level", 32'(btn_level), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        clr();
        t = cyc + 1;
        btn_raw[4] = 1'b1;
        wait_to(t + 5);
        chk("clean_lvl_pre", 32'(btn_level[4]), 0);
        wait_to(t + 6);
        chk("clean_pulse", 32'(btn_pulse[4]), 1);
        chk("clean_lvl_rise", 32'(btn_level[4]), 1);
        wait_to(t + 7);
        chk("clean_pulse_width", 32'(btn_pulse[4]), 0);
        wait_to(t + 99);
        btn_raw[4] = 1'b0;
        r = t + 100;
        wait_to(r + 5);
        chk("clean_lvl_hold", 32'(btn_level[4]), 1);
        wait_to(r + 6);
        chk("clean_lvl_fall", 32'(btn_level[4]), 0);
        wait_to(r + 20);
        chk("clean_count", pc[4], 1);
        chk("clean_time", pt[4][0], t + 6);
        clr();
        for (int k = 0; k < 30; k++) begin
            btn_raw[2] = ((k / 2) % 2) == 0;
            @(negedge clk);
        end
        btn_raw[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce_count", pc[2], 0);
        chk("bounce_level", 32'(lvl_seen[2]), 0);
        clr();
        t = cyc + 1;
        btn_raw[0] = 1'b1;
        wait_to(t + 69);
        btn_raw[0] = 1'b0;
        r = t + 70;
        wait_to(r + 5);
        chk("rep_lvl_hold", 32'(btn_level[0]), 1);
        wait_to(r + 6);
        chk("rep_lvl_fall", 32'(btn_level[0]), 0);
        wait_to(r + 30);
        chk("rep_count", pc[0], 7);
        for (int k = 0; k < 7; k++) chk($sformatf("rep_time%0d", k), pt[0][k], t + rep[k]);
        clr();
        t = cyc + 1;
        btn_raw[1:0] = 2'b11;
        wait_to(t + 35);
        btn_raw[1:0] = 2'b00;
        wait_to(t + 70);
        chk("sim_count0", pc[0], 3);
        chk("sim_count1", pc[1], 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sim_time0_%0d", k), pt[0][k], t + rep[k]);
            chk($sformatf("sim_time1_%0d", k), pt[1][k], t + rep[k]);
        end
        clr();
        t = cyc + 1;
        btn_raw[3] = 1'b1;
        wait_to(t + 6);
        chk("relb_pulse", 32'(btn_pulse[3]), 1);
        btn_raw[3] = 1'b0;
        wait_to(t + 8);
        btn_raw[3] = 1'b1;
        wait_to(t + 9);
        btn_raw[3] = 1'b0;
        wait_to(t + 11);
        chk("relb_lvl_mid", 32'(btn_level[3]), 1);
        wait_to(t + 15);
        chk("relb_lvl_hold", 32'(btn_level[3]), 1);
        wait_to(t + 16);
        chk("relb_lvl_fall", 32'(btn_level[3]), 0);
        wait_to(t + 40);
        chk("relb_count", pc[3], 1);
        clr();
        t = cyc + 1;
        btn_raw[4] = 1'b1;
        wait_to(t + 10);
        chk("rsth_lvl_before", 32'(btn_level[4]), 1);
        #2 reset = 1'b0;
        #1;
        chk("rsth_pulse_async", 32'(btn_pulse), 0);
        chk("rsth_level_async", 32'(btn_level), 0);
        clr();
        wait_to(t + 13);
        reset = 1'b1;
        wait_to(t + 19);
        chk("rsth_pulse_early", 32'(btn_pulse[4]), 0);
        wait_to(t + 20);
        chk("rsth_pulse", 32'(btn_pulse[4]), 1);
        wait_to(t + 45);
        chk("rsth_count", pc[4], 1);
        btn_raw[4] = 1'b0;
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
